// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// opcode constants, branch-type codes and small opcode classifiers.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [4:0] OP_LD      = 5'd16;
  localparam logic [4:0] OP_ST      = 5'd17;
  localparam logic [4:0] OP_BZ      = 5'd18;
  localparam logic [4:0] OP_BNZ     = 5'd19;
  localparam logic [4:0] OP_JMP     = 5'd20;
  localparam logic [4:0] OP_JMR     = 5'd21;
  localparam logic [4:0] OP_NOP_MIN = 5'd22;

  localparam logic [1:0] BR_BZ  = 2'b00;
  localparam logic [1:0] BR_BNZ = 2'b01;
  localparam logic [1:0] BR_JMP = 2'b10;
  localparam logic [1:0] BR_JMR = 2'b11;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op >= OP_BZ) && (op <= OP_JMR);
  endfunction

  // Opcodes 22..31 are reserved and behave as NOP (no register write).
  function automatic logic is_nop_op(input logic [4:0] op);
    return (op >= OP_NOP_MIN);
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational branch-target computation. Conditional branches fall
// through to pc+1 when not taken; all arithmetic wraps at 16 bits.
module branch_unit
  import cpu_pkg::*;
(
  input  logic [1:0]  br_type,
  input  logic        zero,
  input  logic [15:0] pc,
  input  logic [15:0] im_offset,
  input  logic [15:0] jmr_target,
  output logic [15:0] target
);

  logic [15:0] rel_target;
  logic [15:0] seq_target;

  assign rel_target = pc + im_offset;
  assign seq_target = pc + 16'd1;

  // Select the next PC according to the branch type and zero flag.
  always_comb begin
    target = seq_target;
    case (br_type)
      BR_BZ: begin
        if (zero) target = rel_target;
        else      target = seq_target;
      end
      BR_BNZ: begin
        if (!zero) target = rel_target;
        else       target = seq_target;
      end
      BR_JMP:  target = rel_target;
      BR_JMR:  target = jmr_target;
      default: target = seq_target;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch / decode / execute / memory / write-back FSM
// owning the program counter and instruction register.
// Optional feature macro: SEQ_TIMEOUT_EN -- when defined, a wait counter in
// FETCH and MEM sends the FSM to a sticky FAULT state after TIMEOUT_CYC
// cycles without an ack. When undefined, waits are unbounded and fault=0.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [1:0]  br_type,
  input  logic [15:0] im_offset,
  input  logic        load_en,
  input  logic        write_en,
  input  logic        zero,
  input  logic [15:0] jmr_target,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        dmem_we,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fault
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  opcode;
  logic [15:0] br_target;
  logic        timeout_hit;

  assign opcode    = ir[31:27];
  assign imem_addr = pc;

  branch_unit u_branch_unit (
    .br_type    (br_type),
    .zero       (zero),
    .pc         (pc),
    .im_offset  (im_offset),
    .jmr_target (jmr_target),
    .target     (br_target)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYC - 1));

  // Count consecutive cycles spent waiting for an ack in FETCH or MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 16'd0;
    end else if (((state == ST_FETCH) || (state == ST_MEM)) && (next_state == state)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. run is only consulted in IDLE, WB and branch EXEC.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
        else     next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack)         next_state = ST_DECODE;
        else if (timeout_hit) next_state = ST_FAULT;
        else                  next_state = ST_FETCH;
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_op(opcode))         next_state = ST_MEM;
        else if (is_branch_op(opcode)) next_state = run ? ST_FETCH : ST_IDLE;
        else                           next_state = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack)         next_state = ST_WB;
        else if (timeout_hit) next_state = ST_FAULT;
        else                  next_state = ST_MEM;
      end
      ST_WB:    next_state = run ? ST_FETCH : ST_IDLE;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // PC and instruction register updates: load IR on fetch ack, redirect PC
  // on a branch in EXEC, advance PC in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= 32'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) ir <= imem_rdata;
        end
        ST_EXEC: begin
          if (is_branch_op(opcode)) pc <= br_target;
        end
        ST_WB:   pc <= pc + 16'd1;
        default: begin
          pc <= pc;
          ir <= ir;
        end
      endcase
    end
  end

  // Moore-style outputs decoded from the current state.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b1;
    fault    = 1'b0;
    case (state)
      ST_IDLE:   busy = 1'b0;
      ST_FETCH:  imem_req = 1'b1;
      ST_DECODE: busy = 1'b1;
      ST_EXEC:   busy = 1'b1;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = write_en;
      end
      ST_WB:     reg_we = load_en & ~is_nop_op(opcode);
      ST_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of single-instruction
// vectors plus hand-written sequences for run drop, reset during fetch
// and the ack-wait timeout (SEQ_TIMEOUT_EN-dependent).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, run;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata, ir;
  logic [1:0]  br_type;
  logic [15:0] im_offset, jmr_target, pc;
  logic        load_en, write_en, zero;
  logic        dmem_req, dmem_ack, reg_we, dmem_we, busy, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .br_type(br_type), .im_offset(im_offset), .load_en(load_en), .write_en(write_en),
    .zero(zero), .jmr_target(jmr_target), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .dmem_we(dmem_we), .pc(pc), .busy(busy), .fault(fault)
  );

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  br;
    logic [15:0] off;
    logic        zero;
    logic [15:0] jmr;
    logic        load_en;
    logic        write_en;
    int          mem_delay;
    logic [15:0] start_pc;
    logic [15:0] exp_pc;
    int          exp_rw;
    int          exp_dwe;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [1:0] br, input logic [15:0] off,
                              input logic z, input logic [15:0] jmr, input logic le, input logic we,
                              input int md, input logic [15:0] spc, input logic [15:0] epc,
                              input int erw, input int edwe, input int ecyc);
    vec_t v;
    v.op = op; v.br = br; v.off = off; v.zero = z; v.jmr = jmr; v.load_en = le;
    v.write_en = we; v.mem_delay = md; v.start_pc = spc; v.exp_pc = epc;
    v.exp_rw = erw; v.exp_dwe = edwe; v.exp_cyc = ecyc;
    return v;
  endfunction

  task automatic idle_inputs();
    imem_ack = 1'b0; imem_rdata = 32'd0; br_type = 2'b00; im_offset = 16'd0;
    load_en = 1'b0; write_en = 1'b0; zero = 1'b0; jmr_target = 16'd0; dmem_ack = 1'b0;
  endtask

  // Reset, then raise run and step once so the DUT sits in FETCH.
  task automatic reset_to_fetch();
    rst = 1'b1; run = 1'b0; idle_inputs();
    tick();
    rst = 1'b0; run = 1'b1;
    tick();
  endtask

  // Execute one instruction starting in FETCH; returns cycles until the next
  // FETCH, plus the number of reg_we and dmem_we cycles seen on the way.
  task automatic run_instr(input vec_t v, output int cyc, output int rw, output int dwe);
    int mem_n;
    imem_rdata = {v.op, 27'd5};
    br_type = v.br; im_offset = v.off; zero = v.zero; jmr_target = v.jmr;
    load_en = v.load_en; write_en = v.write_en;
    imem_ack = 1'b1; dmem_ack = 1'b0;
    cyc = 0; rw = 0; dwe = 0; mem_n = 0;
    do begin
      if (reg_we) rw++;
      if (dmem_we) dwe++;
      if (dmem_req) begin
        dmem_ack = (mem_n == v.mem_delay);
        mem_n++;
      end else begin
        dmem_ack = 1'b0;
      end
      tick();
      if (cyc == 0) imem_ack = 1'b0;
      cyc++;
    end while (!imem_req && cyc < 30);
    dmem_ack = 1'b0;
  endtask

  initial begin
    int cyc, rw, dwe;
    vec_t j;

    //       op     br     off       z     jmr       le    we    md  start     exp_pc    rw dwe cyc
    vecs[0]  = mk(5'd0,  2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'h0001, 1, 0, 4);
    vecs[1]  = mk(5'd18, 2'b00, 16'h0010, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 16'h0005, 16'h0015, 0, 0, 3);
    vecs[2]  = mk(5'd18, 2'b00, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0005, 16'h0006, 0, 0, 3);
    vecs[3]  = mk(5'd19, 2'b01, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0005, 16'h0015, 0, 0, 3);
    vecs[4]  = mk(5'd19, 2'b01, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 16'h0005, 16'h0006, 0, 0, 3);
    vecs[5]  = mk(5'd21, 2'b11, 16'h0007, 1'b0, 16'h1234, 1'b0, 1'b0, 0, 16'h0000, 16'h1234, 0, 0, 3);
    vecs[6]  = mk(5'd20, 2'b10, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'hFFFF, 16'h0001, 0, 0, 3);
    vecs[7]  = mk(5'd22, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0003, 16'h0004, 0, 0, 4);
    vecs[8]  = mk(5'd31, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'hFFFF, 16'h0000, 0, 0, 4);
    vecs[9]  = mk(5'd17, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 16'h0000, 16'h0001, 0, 4, 8);
    vecs[10] = mk(5'd16, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'h0001, 1, 0, 5);
    vecs[11] = mk(5'd15, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 16'h0001, 0, 0, 4);

    // Reset state.
    rst = 1'b1; run = 1'b0; idle_inputs();
    tick(); tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b0;
    tick(); tick();
    check("idle_hold_busy", busy, 1'b0);

    // Table-driven single instructions.
    for (int i = 0; i < 12; i++) begin
      reset_to_fetch();
      if (vecs[i].start_pc != 16'h0000) begin
        j = vecs[i];
        j.op = 5'd21; j.br = 2'b11; j.jmr = vecs[i].start_pc;
        j.load_en = 1'b0; j.write_en = 1'b0; j.mem_delay = 0;
        run_instr(j, cyc, rw, dwe);
      end
      run_instr(vecs[i], cyc, rw, dwe);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_ir", i), ir, {vecs[i].op, 27'd5});
      check($sformatf("vec%0d_reg_we_cycles", i), rw, vecs[i].exp_rw);
      check($sformatf("vec%0d_dmem_we_cycles", i), dwe, vecs[i].exp_dwe);
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
    end

    // run dropped during MEM of an LD: LD completes, then IDLE.
    reset_to_fetch();
    imem_rdata = {5'd16, 27'd0}; load_en = 1'b1; write_en = 1'b0; imem_ack = 1'b1;
    tick(); imem_ack = 1'b0;
    tick();
    tick();
    check("ld_mem_req", dmem_req, 1'b1);
    check("ld_mem_we", dmem_we, 1'b0);
    run = 1'b0;
    tick();
    check("ld_mem_wait", dmem_req, 1'b1);
    check("ld_mem_wait_reg_we", reg_we, 1'b0);
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    check("ld_wb_reg_we", reg_we, 1'b1);
    check("ld_wb_busy", busy, 1'b1);
    tick();
    check("ld_idle_busy", busy, 1'b0);
    check("ld_idle_reg_we", reg_we, 1'b0);
    check("ld_idle_pc", pc, 16'h0001);
    tick();
    check("ld_idle_hold", imem_req, 1'b0);

    // Branch with run low at EXEC returns to IDLE after redirecting PC.
    run = 1'b1;
    tick();
    imem_rdata = {5'd20, 27'd0}; br_type = 2'b10; im_offset = 16'h0003; imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; run = 1'b0;
    tick();
    tick();
    check("jmp_stop_busy", busy, 1'b0);
    check("jmp_stop_pc", pc, 16'h0004);

    // Reset asserted in FETCH together with an ack: reset wins.
    run = 1'b1;
    tick();
    check("fetch_addr", imem_addr, 16'h0004);
    imem_rdata = {5'd0, 27'd9}; imem_ack = 1'b1; rst = 1'b1;
    tick();
    check("rst_ack_pc", pc, 16'h0000);
    check("rst_ack_ir", ir, 32'd0);
    check("rst_ack_busy", busy, 1'b0);
    check("rst_ack_imem_req", imem_req, 1'b0);
    rst = 1'b0; imem_ack = 1'b0; run = 1'b0;
    tick();
    check("rst_ack_idle", busy, 1'b0);

    // Fetch ack withheld: 14 cycles is still waiting, 15 is the limit.
    reset_to_fetch();
    repeat (14) tick();
    check("wait14_fault", fault, 1'b0);
    check("wait14_busy", busy, 1'b1);
`ifdef SEQ_TIMEOUT_EN
    tick();
    check("to_fault", fault, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_imem_req", imem_req, 1'b0);
    imem_ack = 1'b1;
    repeat (3) tick();
    check("to_sticky", fault, 1'b1);
    imem_ack = 1'b0; rst = 1'b1;
    tick();
    check("to_rst_clear", fault, 1'b0);
    rst = 1'b0;
`else
    repeat (40) tick();
    check("nto_fault", fault, 1'b0);
    check("nto_still_fetch", imem_req, 1'b1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("nto_ack_leaves_fetch", imem_req, 1'b0);
    check("nto_ack_busy", busy, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
